pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 32: width of the period and high-time counters and registers (8..32).
REQ-002 Parameter TIMEOUT_RST, default 32'd50_000_000: reset value of the TIMEOUT register (1 s at 50 MHz).
REQ-003 Port clk, input, 1: single system clock; all logic is rising-edge clocked.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Port pwm_in, input, 1: external PWM signal, asynchronous to clk (GPIO pin).
REQ-006 Port chipselect, input, 1: Avalon-MM slave select.
REQ-007 Port address, input, 2: word register index.
REQ-008 Port read, input, 1: read strobe.
REQ-009 Port write, input, 1: write strobe.
REQ-010 Port writedata, input, 32: write data.
REQ-011 Port readdata, output, 32: registered read data.
REQ-012 Port irq, output, 1: level interrupt, active-high.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop (s3); rise = s2 & ~s3, fall = ~s2 & s3.
REQ-014 Register map: 0 PERIOD (RO), 1 HIGH (RO), 2 CTRL/STATUS, 3 TIMEOUT (RW); CNT_W values are zero-extended to 32 bits.
REQ-015 CTRL/STATUS: bit0 EN (RW), bit1 IRQ_EN (RW), bit2 VALID (RO), bit3 TOUT (W1C), bit4 OVR (W1C), bit5 LEVEL (RO, = s2).
REQ-016 readdata SHALL update one cycle after a cycle with chipselect & read (read latency 1) and hold its value otherwise; a read of PERIOD SHALL clear VALID in that same cycle.
REQ-017 A write with chipselect & write SHALL take effect at the next clock edge; writes to addresses 0 and 1 are ignored.
REQ-018 FSM states: IDLE, ARM, MEAS.
REQ-019 IDLE: counters held at 0; EN=1 -> ARM.
REQ-020 ARM: waits for rise; on rise -> MEAS with per_cnt<=0, hi_cnt<=1.
REQ-021 MEAS: each cycle per_cnt+=1 and, while s2=1, hi_cnt+=1.
REQ-022 On rise in MEAS: PERIOD<=per_cnt+1 and HIGH<=hi_cnt; if VALID is already 1, OVR<=1; VALID<=1; counters restart as in REQ-020; state remains MEAS.
REQ-023 Timeout: in MEAS, if per_cnt+1 == TIMEOUT with no rise -> PERIOD<=0, HIGH<=0 if s2=0 else all-ones, TOUT<=1, VALID<=1, state -> ARM.
REQ-024 ARM has no timeout.
REQ-025 A TIMEOUT write of 0 SHALL be stored as 1.
REQ-026 EN cleared in any state -> IDLE next cycle; PERIOD, HIGH and the status flags are retained.
REQ-027 Simultaneous latch (REQ-022) and PERIOD read in the same cycle: the new sample wins, so VALID=1 afterwards; readdata returns the old PERIOD.
REQ-028 Simultaneous latch and OVR/TOUT W1C write in the same cycle: the set wins.
REQ-029 irq = IRQ_EN & (VALID | TOUT), registered, asserted one cycle after the flag sets.
REQ-030 A duty of 0% or 100% SHALL manifest as a timeout (no rise); HIGH encodes the static level.
REQ-031 Minimum measurable pulse: high or low phase of 1 cycle of s2; shorter pin glitches may be lost by the synchronizer without error.

Reset
REQ-032 On reset_n=0 at a clock edge: state=IDLE; per_cnt=hi_cnt=0; PERIOD=HIGH=0; EN=IRQ_EN=VALID=TOUT=OVR=0; TIMEOUT=TIMEOUT_RST; readdata=0; irq=0; s1=s2=s3=0.
REQ-033 Reset asserted mid-measurement SHALL discard the partial counts with no latch.

Verification
REQ-034 Basic: EN=1, pwm_in period 100 clk, high 25 -> after the 2nd rise, PERIOD=100, HIGH=25, VALID=1; a read of addr 0 returns 100 and clears VALID.
REQ-035 Overrun: no reads over 3 periods of 40/10 -> OVR=1, PERIOD=40; a W1C write of 0x10 to addr 2 clears OVR.
REQ-036 Timeout: TIMEOUT=500, pwm_in held high after 1 rise -> 500 cycles later PERIOD=0, HIGH=all-ones, TOUT=1, FSM=ARM; with IRQ_EN=1, irq=1 the next cycle.
REQ-037 Collision: latch in the same cycle as a PERIOD read -> readdata holds the old value, VALID stays 1.
REQ-038 Disable/reset: EN cleared mid-period -> IDLE, registers retained; reset_n low mid-MEAS -> all values per REQ-032, and the first latch after re-enable requires 2 rises.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with an Avalon-MM slave register interface.
//
// Ports:
//   clk         system clock, everything is clocked on the rising edge
//   reset_n     synchronous active-low reset
//   pwm_in      external PWM pin, asynchronous to clk
//   chipselect  Avalon-MM slave select
//   address     word register index (0 PERIOD, 1 HIGH, 2 CTRL/STATUS, 3 TIMEOUT)
//   read        read strobe (read latency 1)
//   write       write strobe
//   writedata   write data
//   readdata    registered read data
//   irq         level interrupt, IRQ_EN & (VALID | TOUT), registered
//
// CTRL/STATUS bits: 0 EN, 1 IRQ_EN, 2 VALID (RO), 3 TOUT (W1C), 4 OVR (W1C),
// 5 LEVEL (RO, synchronized pin level).
module pwm_capture #(
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] TIMEOUT_RST = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic [CNT_W-1:0]    per_cnt;
  logic [CNT_W-1:0]    hi_cnt;
  logic [CNT_W-1:0]    period_r;
  logic [CNT_W-1:0]    high_r;
  logic [DATA_W-1:0]   timeout;
  logic                en, irq_en, valid, tout, ovr;

  logic                rise;
  logic                wr_en;
  logic                rd_en;
  logic [CNT_W-1:0]    per_inc;
  logic [DATA_W-1:0]   status;

  assign rise    = s2 & ~s3;
  assign wr_en   = chipselect & write;
  assign rd_en   = chipselect & read;
  assign per_inc = per_cnt + CNT_W'(1);
  assign status  = {26'd0, s2, ovr, tout, valid, irq_en, en};

  // Pin synchronizer plus delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Register file and measurement FSM. The FSM section comes last so that a
  // latch or timeout setting a flag overrides a same-cycle clear from the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      period_r <= '0;
      high_r   <= '0;
      timeout  <= TIMEOUT_RST;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      valid    <= 1'b0;
      tout     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          2'd2: begin
            en     <= writedata[0];
            irq_en <= writedata[1];
            if (writedata[3]) tout <= 1'b0;
            if (writedata[4]) ovr  <= 1'b0;
          end
          // A zero timeout would never match, so it is stored as 1.
          2'd3: timeout <= (writedata == '0) ? DATA_W'(1) : writedata;
          default: ;
        endcase
      end

      if (rd_en && address == 2'd0) valid <= 1'b0;

      if (!en) begin
        state   <= IDLE;
        per_cnt <= '0;
        hi_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end

          ARM: begin
            if (rise) begin
              state   <= MEAS;
              per_cnt <= '0;
              hi_cnt  <= CNT_W'(1);
            end
          end

          MEAS: begin
            if (rise) begin
              // The rise cycle itself opens the next period, hence +1 / restart at 1.
              period_r <= per_inc;
              high_r   <= hi_cnt;
              if (valid) ovr <= 1'b1;
              valid    <= 1'b1;
              per_cnt  <= '0;
              hi_cnt   <= CNT_W'(1);
            end else if (DATA_W'(per_inc) == timeout) begin
              // No edge: report a static level (0% or 100% duty).
              period_r <= '0;
              high_r   <= s2 ? '1 : '0;
              tout     <= 1'b1;
              valid    <= 1'b1;
              state    <= ARM;
              per_cnt  <= '0;
              hi_cnt   <= '0;
            end else begin
              per_cnt <= per_inc;
              if (s2) hi_cnt <= hi_cnt + CNT_W'(1);
            end
          end

          default: begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end
        endcase
      end
    end
  end

  // Read data port and interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= irq_en & (valid | tout);
      if (rd_en) begin
        case (address)
          2'd0:    readdata <= DATA_W'(period_r);
          2'd1:    readdata <= DATA_W'(high_r);
          2'd2:    readdata <= status;
          default: readdata <= timeout;
        endcase
      end
    end
  end

endmodule
